// File: rtl/fb_pkg.sv
// Shared constants for the MEM stage: datapath width, load/store size codes,
// and MEM-stage FSM state encoding.
package fb_pkg;

  localparam int FB_32BITS = 32;

  localparam logic [2:0] FB_F3_LB  = 3'b000;
  localparam logic [2:0] FB_F3_LH  = 3'b001;
  localparam logic [2:0] FB_F3_LW  = 3'b010;
  localparam logic [2:0] FB_F3_LBU = 3'b100;
  localparam logic [2:0] FB_F3_LHU = 3'b101;

  typedef enum logic {
    FB_MS_IDLE = 1'b0,
    FB_MS_WAIT = 1'b1
  } fb_ms_e;

  typedef enum logic [1:0] {
    FB_SZ_B = 2'd0,
    FB_SZ_H = 2'd1,
    FB_SZ_W = 2'd2
  } fb_size_e;

  // Access size from funct3; unlisted codes behave as a full word.
  function automatic fb_size_e fb_size(input logic [2:0] f3);
    case (f3)
      FB_F3_LB, FB_F3_LBU: fb_size = FB_SZ_B;
      FB_F3_LH, FB_F3_LHU: fb_size = FB_SZ_H;
      FB_F3_LW:            fb_size = FB_SZ_W;
      default:             fb_size = FB_SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/fb_load_ext.sv
// Load data alignment: picks the addressed byte/half out of the read word and
// sign- or zero-extends it according to funct3.
module fb_load_ext
  import fb_pkg::*;
(
  input  logic [FB_32BITS-1:0] rdata,
  input  logic [1:0]           addr,
  input  logic [2:0]           funct3,
  output logic [FB_32BITS-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension.
  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      FB_F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      FB_F3_LH:  data = {{16{half_sel[15]}}, half_sel};
      FB_F3_LBU: data = {24'h0, byte_sel};
      FB_F3_LHU: data = {16'h0, half_sel};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/fb_memstage.sv
// MEM pipeline stage: req/ack data-memory handshake with byte enables, load
// extension, upstream stall and the MEM/WB register.
// Optional bus-error timeout on a missing ack: define FB_MEM_TIMEOUT_EN.
//
// state      | meaning
// FB_MS_IDLE | no outstanding request; zero-wait accesses complete here
// FB_MS_WAIT | request issued, waiting for dmem_ack with inputs frozen
module fb_memstage
  import fb_pkg::*;
`ifdef FB_MEM_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int TO_W        = 5
)
`endif
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_mem_read,
  input  logic                 mem_mem_write,
  input  logic                 mem_mem_to_reg,
  input  logic                 mem_reg_write,
  input  logic [2:0]           mem_funct3,
  input  logic [FB_32BITS-1:0] mem_alu_res,
  input  logic [FB_32BITS-1:0] mem_rs2_data,
  input  logic [4:0]           mem_register_rd,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [FB_32BITS-1:0] dmem_addr,
  output logic [3:0]           dmem_be,
  output logic [FB_32BITS-1:0] dmem_wdata,
  input  logic                 dmem_ack,
  input  logic [FB_32BITS-1:0] dmem_rdata,
  output logic                 mem_stall,
  output logic                 mem_misalign,
`ifdef FB_MEM_TIMEOUT_EN
  output logic                 mem_buserr,
`endif
  output logic                 wb_mem_to_reg,
  output logic                 wb_reg_write,
  output logic [FB_32BITS-1:0] wb_alu_res,
  output logic [FB_32BITS-1:0] wb_mem_data,
  output logic [4:0]           wb_register_rd
);

  fb_ms_e                 state_q, state_d;
  fb_size_e               size;
  logic                   access, misalign, go, done, to_err;
  logic [FB_32BITS-1:0]   ext_data;

  assign access   = mem_mem_read | mem_mem_write;
  assign size     = fb_size(mem_funct3);
  assign misalign = access & (((size == FB_SZ_H) & mem_alu_res[0]) |
                              ((size == FB_SZ_W) & (|mem_alu_res[1:0])));
  assign go       = access & ~misalign;
  assign done     = go & dmem_ack;

`ifdef FB_MEM_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  // Wait-cycle counter; sits at zero in IDLE so it is clear on entering WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        to_cnt <= '0;
    else if (state_q == FB_MS_WAIT) to_cnt <= to_cnt + 1'b1;
    else                            to_cnt <= '0;
  end

  assign to_err     = go & (state_q == FB_MS_WAIT) & ~dmem_ack &
                      (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign mem_buserr = to_err;
`else
  assign to_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FB_MS_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: leave IDLE on an unacked request, return on ack or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FB_MS_IDLE: if (go && !dmem_ack) state_d = FB_MS_WAIT;
      FB_MS_WAIT: if (!go || dmem_ack || to_err) state_d = FB_MS_IDLE;
    endcase
  end

  assign dmem_req     = go;
  assign dmem_we      = mem_mem_write;
  assign dmem_addr    = {mem_alu_res[31:2], 2'b00};
  assign mem_stall    = go & ~dmem_ack & ~to_err;
  assign mem_misalign = misalign;

  // Store lane placement; loads read the whole word.
  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = mem_rs2_data;
    if (mem_mem_write) begin
      case (size)
        FB_SZ_B: begin
          dmem_be    = 4'b0001 << mem_alu_res[1:0];
          dmem_wdata = {4{mem_rs2_data[7:0]}};
        end
        FB_SZ_H: begin
          dmem_be    = 4'b0011 << mem_alu_res[1:0];
          dmem_wdata = {2{mem_rs2_data[15:0]}};
        end
        default: begin
          dmem_be    = 4'b1111;
          dmem_wdata = mem_rs2_data;
        end
      endcase
    end
  end

  fb_load_ext u_load_ext (
    .rdata  (dmem_rdata),
    .addr   (mem_alu_res[1:0]),
    .funct3 (mem_funct3),
    .data   (ext_data)
  );

  // MEM/WB register: bubble while stalled, otherwise capture; dropped or
  // errored accesses never write the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_mem_to_reg  <= 1'b0;
      wb_reg_write   <= 1'b0;
      wb_alu_res     <= '0;
      wb_mem_data    <= '0;
      wb_register_rd <= '0;
    end else if (mem_stall) begin
      wb_mem_to_reg  <= 1'b0;
      wb_reg_write   <= 1'b0;
    end else begin
      wb_mem_to_reg  <= mem_mem_to_reg;
      wb_reg_write   <= mem_reg_write & ~misalign & ~to_err;
      wb_alu_res     <= mem_alu_res;
      wb_mem_data    <= (done && mem_mem_read) ? ext_data : '0;
      wb_register_rd <= mem_register_rd;
    end
  end

endmodule

// File: tb/tb_fb_memstage.sv
// Directed bench for fb_memstage: stores, loads with wait states, misaligned
// drops, reset mid-transaction and (when enabled) the ack timeout.
module tb_fb_memstage;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_res, mem_rs2_data;
  logic [4:0]  mem_register_rd;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        mem_stall, mem_misalign;
  logic        wb_mem_to_reg, wb_reg_write;
  logic [31:0] wb_alu_res, wb_mem_data;
  logic [4:0]  wb_register_rd;
`ifdef FB_MEM_TIMEOUT_EN
  logic        mem_buserr;
`endif

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  fb_memstage dut (
    .clk(clk), .rst(rst),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_reg_write(mem_reg_write),
    .mem_funct3(mem_funct3), .mem_alu_res(mem_alu_res),
    .mem_rs2_data(mem_rs2_data), .mem_register_rd(mem_register_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .mem_misalign(mem_misalign),
`ifdef FB_MEM_TIMEOUT_EN
    .mem_buserr(mem_buserr),
`endif
    .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
    .wb_alu_res(wb_alu_res), .wb_mem_data(wb_mem_data),
    .wb_register_rd(wb_register_rd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    mem_mem_read = 0; mem_mem_write = 0; mem_mem_to_reg = 0; mem_reg_write = 0;
    mem_funct3 = 3'b010; mem_alu_res = 0; mem_rs2_data = 0; mem_register_rd = 0;
    dmem_ack = 0; dmem_rdata = 0;
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                      input logic [31:0] rdata, input logic ack);
    nop();
    mem_mem_read = 1; mem_mem_to_reg = 1; mem_reg_write = 1;
    mem_funct3 = f3; mem_alu_res = a; mem_register_rd = rd;
    dmem_rdata = rdata; dmem_ack = ack;
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    nop();
    mem_mem_write = 1; mem_funct3 = f3; mem_alu_res = a; mem_rs2_data = d; dmem_ack = 1;
  endtask

  initial begin
    rst = 1;
    nop();
    #2;
    check("rst_wb_reg_write", 32'(wb_reg_write), 0);
    check("rst_wb_alu_res", wb_alu_res, 0);
    check("rst_dmem_req", 32'(dmem_req), 0);
    tick();
    rst = 0;

    // SW zero-wait
    store(3'b010, 32'h100, 32'hDEADBEEF);
    #1;
    check("sw_req", 32'(dmem_req), 1);
    check("sw_we", 32'(dmem_we), 1);
    check("sw_be", 32'(dmem_be), 32'hF);
    check("sw_wdata", dmem_wdata, 32'hDEADBEEF);
    check("sw_addr", dmem_addr, 32'h100);
    check("sw_stall", 32'(mem_stall), 0);
    tick();
    check("sw_wb_reg_write", 32'(wb_reg_write), 0);
    nop();

    // LB 0x103 with three wait cycles
    tick();
    load(3'b000, 32'h103, 5'd7, 32'h80FF0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lb_stall", 32'(mem_stall), 1);
      check("lb_req", 32'(dmem_req), 1);
      check("lb_we", 32'(dmem_we), 0);
      check("lb_be", 32'(dmem_be), 32'hF);
      check("lb_addr", dmem_addr, 32'h100);
      tick();
      check("lb_bubble", 32'(wb_reg_write), 0);
    end
    dmem_ack = 1;
    #1;
    check("lb_ack_stall", 32'(mem_stall), 0);
    tick();
    check("lb_wb_data", wb_mem_data, 32'hFFFFFF80);
    check("lb_wb_rd", 32'(wb_register_rd), 7);
    check("lb_wb_reg_write", 32'(wb_reg_write), 1);
    check("lb_wb_mem_to_reg", 32'(wb_mem_to_reg), 1);
    check("lb_wb_alu_res", wb_alu_res, 32'h103);

    // LHU / LH / LBU zero-wait
    load(3'b101, 32'h202, 5'd9, 32'hBEEF1234, 1'b1);
    tick();
    check("lhu_wb_data", wb_mem_data, 32'h0000BEEF);
    load(3'b001, 32'h200, 5'd9, 32'h12348001, 1'b1);
    tick();
    check("lh_wb_data", wb_mem_data, 32'hFFFF8001);
    load(3'b100, 32'h101, 5'd9, 32'h00009A00, 1'b1);
    tick();
    check("lbu_wb_data", wb_mem_data, 32'h0000009A);

    // SH / SB lane placement
    store(3'b001, 32'h202, 32'h5555ABCD);
    #1;
    check("sh_be", 32'(dmem_be), 32'hC);
    check("sh_wdata", dmem_wdata, 32'hABCDABCD);
    tick();
    store(3'b000, 32'h101, 32'h00000012);
    #1;
    check("sb_be", 32'(dmem_be), 32'h2);
    check("sb_wdata", dmem_wdata, 32'h12121212);
    tick();

    // Misaligned LW
    load(3'b010, 32'h101, 5'd4, 32'h11111111, 1'b0);
    #1;
    check("mis_req", 32'(dmem_req), 0);
    check("mis_flag", 32'(mem_misalign), 1);
    check("mis_stall", 32'(mem_stall), 0);
    tick();
    check("mis_wb_reg_write", 32'(wb_reg_write), 0);
    nop();
    #1;
    check("mis_pulse_end", 32'(mem_misalign), 0);

    // Unlisted funct3 behaves as word
    load(3'b011, 32'h102, 5'd4, 32'h0, 1'b0);
    #1;
    check("f3x_misalign", 32'(mem_misalign), 1);
    tick();

    // Non-memory pass-through, with a stray ack
    nop();
    mem_reg_write = 1; mem_alu_res = 32'h1234; mem_register_rd = 5'd3;
    dmem_ack = 1; dmem_rdata = 32'hFFFFFFFF;
    #1;
    check("alu_req", 32'(dmem_req), 0);
    check("alu_stall", 32'(mem_stall), 0);
    tick();
    check("alu_wb_alu_res", wb_alu_res, 32'h1234);
    check("alu_wb_rd", 32'(wb_register_rd), 3);
    check("alu_wb_reg_write", 32'(wb_reg_write), 1);
    check("alu_wb_mem_data", wb_mem_data, 0);

    // Reset in the middle of a WAIT
    load(3'b010, 32'h300, 5'd5, 32'h0, 1'b0);
    tick();
    check("rstw_stall", 32'(mem_stall), 1);
    #2;
    rst = 1;
    #1;
    check("rstw_wb_alu_res", wb_alu_res, 0);
    check("rstw_wb_rd", 32'(wb_register_rd), 0);
    nop();
    tick();
    rst = 0;
    #1;
    check("rstw_req", 32'(dmem_req), 0);
    load(3'b010, 32'h304, 5'd6, 32'hCAFEF00D, 1'b1);
    tick();
    check("rstw_next_load", wb_mem_data, 32'hCAFEF00D);
    nop();

`ifdef FB_MEM_TIMEOUT_EN
    load(3'b010, 32'h400, 5'd8, 32'h0, 1'b0);
    #1;
    check("to_first_stall", 32'(mem_stall), 1);
    for (int i = 0; i < 15; i++) begin
      tick();
      check("to_wait_stall", 32'(mem_stall), 1);
      check("to_wait_buserr", 32'(mem_buserr), 0);
    end
    tick();
    check("to_buserr", 32'(mem_buserr), 1);
    check("to_stall_drop", 32'(mem_stall), 0);
    tick();
    check("to_wb_reg_write", 32'(wb_reg_write), 0);
    nop();
    dmem_ack = 1;
    #1;
    check("to_late_ack_stall", 32'(mem_stall), 0);
    check("to_late_ack_buserr", 32'(mem_buserr), 0);
    tick();
    nop();
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
